seq_core_debug_cmd_initiator: RTL and testbench
===============================================

# seq_core_debug_cmd_initiator

Host-side initiator for the sequencer core debug command mailbox. Accepts one debug command at a time from a local requester, e.g. a JTAG/PCIe debug bridge. Writes the parameters and the request opcode into the sequencer's debug region over an Avalon-MM master, then polls the command status word until the sequencer reports completion or a poll budget expires. Sits on the sequencer's Avalon-MM fabric, alongside the Nios-side firmware that services the mailbox.

## Interface
Parameters:
- ADDR_WIDTH, 20, Avalon byte-address width
- REQ_CMD_ADDR, 'h15f90, byte address of request-command word
- CMD_STATUS_ADDR, 'h15f94, byte address of command-status word
- CMD_PARAMS_ADDR, 'h15f98, byte address of parameter word 0; word k at +4k
- POLL_GAP, 16, idle cycles between status polls (≥1)
- MAX_POLLS, 1024, status reads before timeout (≥1)

Ports (one clock; reset is asynchronous and active-low):
- avl_clk  in  1  clock
- avl_reset_n  in  1  async active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_opcode  in  32  command opcode; 0 is illegal
- cmd_nparams  in  3  parameter count 0..4; values 5..7 clamp to 4
- cmd_params  in  128  word k = bits [32k+31:32k]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_status  out  32  final status word; held until next response
- rsp_timeout  out  1  qualifies rsp_valid; poll budget exhausted
- avl_address  out  ADDR_WIDTH  byte address
- avl_write  out  1  write strobe
- avl_read  out  1  read strobe
- avl_writedata  out  32  write data
- avl_readdata  in  32  read data
- avl_readdatavalid  in  1  read data qualifier
- avl_waitrequest  in  1  slave stall

## Operation
- Mailbox protocol: initiator clears CMD_STATUS to 0, writes parameters, writes REQ_CMD=opcode. Sequencer executes, clears REQ_CMD, writes nonzero CMD_STATUS: 1 = success, others = error code.
- FSM states: IDLE, CLR_STAT, WR_PARAM, WR_CMD, GAP, RD_STAT, RD_WAIT, ABORT, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch opcode, params and clamped count. Go to RESP if opcode==0 (rsp_status='hFFFF_FFFF, rsp_timeout=0, no bus traffic); otherwise go to CLR_STAT.
- CLR_STAT: write 0 to CMD_STATUS_ADDR. Go to WR_PARAM if count>0, else WR_CMD.
- WR_PARAM: write params in order 0..count-1 to CMD_PARAMS_ADDR+4k. Go to WR_CMD.
- WR_CMD: write opcode to REQ_CMD_ADDR. Clear poll counter. Go to GAP.
- GAP: count POLL_GAP cycles, then RD_STAT.
- RD_STAT: assert read of CMD_STATUS_ADDR. Once accepted, go to RD_WAIT.
- RD_WAIT: wait for avl_readdatavalid.
  - Data nonzero: latch into rsp_status, go to RESP.
  - Data zero: increment poll counter. If count equals MAX_POLLS, go to ABORT; else go to GAP.
- ABORT: write 0 to REQ_CMD_ADDR so firmware ignores a late request. Set rsp_status=0 and rsp_timeout=1. Go to RESP.
- RESP: rsp_valid=1 for one cycle, then IDLE.
- One bus transaction outstanding at a time; avl_write and avl_read are never both high.
- Readdatavalid outside RD_WAIT is ignored.

## Timing
- Reset values: cmd_ready=0 during reset and 1 from the first clock after deassertion. rsp_valid=0, rsp_status=0, rsp_timeout=0, avl_write=0, avl_read=0, avl_address=0, avl_writedata=0.
- Bus rules:
  - Strobe, address and data are registered outputs.
  - They hold stable while avl_waitrequest=1.
  - A transfer completes on the edge where the strobe is high and waitrequest is low.
  - The next strobe may assert on the following cycle (back-to-back).
- With waitrequest=0 and n params, the handshake is cycle 0:
  - Cycle 1: CMD_STATUS clear written.
  - Cycles 2..n+1: parameter writes.
  - Cycle n+2: REQ_CMD write.
  - First read strobe at n+3+POLL_GAP.
  - Success: rsp_valid one cycle after the readdatavalid that carries nonzero data.
- Opcode 0: rsp_valid on cycle 1.
- Timeout: ABORT write follows the MAX_POLLS-th zero read; rsp_valid one cycle after that write completes.
- rsp_timeout and rsp_status are updated on the same cycle that rsp_valid rises.
- cmd_valid while busy is ignored (cmd_ready=0); no queueing.
- Reset asserted mid-transaction:
  - All outputs return to reset values asynchronously.
  - An in-flight transfer is abandoned, with no completion and no response.
- Poll counter width is clog2(MAX_POLLS+1); it never wraps.

## Test plan
- Opcode 'h5, nparams=2, params 'hA,'hB, waitrequest=0, status read 0,0,1 → writes (15f94←0),(15f98←A),(15f9c←B),(15f90←5), three reads, rsp_valid with rsp_status=1, rsp_timeout=0.
- waitrequest held high 3 cycles on each transfer → strobe, address and data stable; same write sequence; no duplicated writes.
- MAX_POLLS=4, status always 0 → four reads, then write 15f90←0, rsp_valid with rsp_status=0, rsp_timeout=1.
- Opcode 0 → no bus activity; rsp_valid on cycle 1 with rsp_status='hFFFF_FFFF.
- nparams=7 → exactly four parameter writes, 15f98..15fa4; cmd_valid pulsed while busy is ignored (cmd_ready=0).
- avl_reset_n low during a parameter write → avl_write=0 and cmd_ready=0 immediately, no rsp_valid; after release, new command completes normally.

Source files
------------

// File: rtl/seq_core_debug_cmd_initiator.sv
// Host-side initiator for the sequencer debug mailbox: clears status, writes params and opcode
// over Avalon-MM, then polls the status word until completion or poll-budget timeout.
module seq_core_debug_cmd_initiator #(
    parameter int unsigned ADDR_WIDTH      = 20,
    parameter int unsigned REQ_CMD_ADDR    = 'h15f90,
    parameter int unsigned CMD_STATUS_ADDR = 'h15f94,
    parameter int unsigned CMD_PARAMS_ADDR = 'h15f98,
    parameter int unsigned POLL_GAP        = 16,
    parameter int unsigned MAX_POLLS       = 1024
) (
    input  logic                  avl_clk,
    input  logic                  avl_reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_opcode,
    input  logic [2:0]            cmd_nparams,
    input  logic [127:0]          cmd_params,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_status,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] avl_address,
    output logic                  avl_write,
    output logic                  avl_read,
    output logic [31:0]           avl_writedata,
    input  logic [31:0]           avl_readdata,
    input  logic                  avl_readdatavalid,
    input  logic                  avl_waitrequest
);
    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam int GW = $clog2(POLL_GAP + 1);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    localparam addr_t REQ_A  = addr_t'(REQ_CMD_ADDR);
    localparam addr_t STAT_A = addr_t'(CMD_STATUS_ADDR);
    localparam addr_t PAR_A  = addr_t'(CMD_PARAMS_ADDR);

    typedef enum logic [3:0] {
        IDLE, CLR_STAT, WR_PARAM, WR_CMD, GAP, RD_STAT, RD_WAIT, ABORT, RESP
    } state_t;

    state_t         state, state_n;
    logic [31:0]    opcode_q, opcode_n;
    logic [127:0]   params_q, params_n;
    logic [2:0]     count_q, count_n;
    logic [1:0]     idx_q, idx_n;
    logic [2:0]     idx_inc;
    logic [PW-1:0]  poll_q, poll_n, poll_inc;
    logic [GW-1:0]  gap_q, gap_n;
    addr_t          addr_n;
    logic           wr_n, rd_n, rdy_n, rv_n, rt_n;
    logic [31:0]    wd_n, rs_n;

    function automatic logic [31:0] param_word(input logic [127:0] p, input logic [1:0] k);
        return p[{k, 5'b0} +: 32];
    endfunction

    function automatic addr_t param_addr(input logic [1:0] k);
        return PAR_A + addr_t'({k, 2'b00});
    endfunction

    assign idx_inc  = {1'b0, idx_q} + 3'd1;
    assign poll_inc = poll_q + 1'b1;

    always_comb begin
        state_n  = state;
        opcode_n = opcode_q;
        params_n = params_q;
        count_n  = count_q;
        idx_n    = idx_q;
        poll_n   = poll_q;
        gap_n    = gap_q;
        addr_n   = avl_address;
        wr_n     = avl_write;
        rd_n     = avl_read;
        wd_n     = avl_writedata;
        rdy_n    = cmd_ready;
        rv_n     = 1'b0;
        rs_n     = rsp_status;
        rt_n     = rsp_timeout;
        case (state)
            IDLE: begin
                rdy_n = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    rdy_n    = 1'b0;
                    opcode_n = cmd_opcode;
                    params_n = cmd_params;
                    count_n  = (cmd_nparams > 3'd4) ? 3'd4 : cmd_nparams;
                    if (cmd_opcode == 32'd0) begin
                        rv_n    = 1'b1;
                        rs_n    = 32'hFFFF_FFFF;
                        rt_n    = 1'b0;
                        state_n = RESP;
                    end else begin
                        wr_n    = 1'b1;
                        addr_n  = STAT_A;
                        wd_n    = '0;
                        state_n = CLR_STAT;
                    end
                end
            end
            // Each write state stages the next transfer on the edge its own transfer completes.
            CLR_STAT: if (!avl_waitrequest) begin
                if (count_q != 3'd0) begin
                    idx_n   = 2'd0;
                    addr_n  = param_addr(2'd0);
                    wd_n    = param_word(params_q, 2'd0);
                    state_n = WR_PARAM;
                end else begin
                    addr_n  = REQ_A;
                    wd_n    = opcode_q;
                    state_n = WR_CMD;
                end
            end
            WR_PARAM: if (!avl_waitrequest) begin
                if (idx_inc == count_q) begin
                    addr_n  = REQ_A;
                    wd_n    = opcode_q;
                    state_n = WR_CMD;
                end else begin
                    idx_n  = idx_inc[1:0];
                    addr_n = param_addr(idx_inc[1:0]);
                    wd_n   = param_word(params_q, idx_inc[1:0]);
                end
            end
            WR_CMD: if (!avl_waitrequest) begin
                wr_n    = 1'b0;
                poll_n  = '0;
                gap_n   = '0;
                state_n = GAP;
            end
            GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) begin
                    rd_n    = 1'b1;
                    addr_n  = STAT_A;
                    state_n = RD_STAT;
                end else begin
                    gap_n = gap_q + 1'b1;
                end
            end
            RD_STAT: if (!avl_waitrequest) begin
                rd_n    = 1'b0;
                state_n = RD_WAIT;
            end
            RD_WAIT: if (avl_readdatavalid) begin
                if (avl_readdata != 32'd0) begin
                    rv_n    = 1'b1;
                    rs_n    = avl_readdata;
                    rt_n    = 1'b0;
                    state_n = RESP;
                end else begin
                    poll_n = poll_inc;
                    if (poll_inc == PW'(MAX_POLLS)) begin
                        // Withdraw the request so firmware ignores it if it wakes up late.
                        wr_n    = 1'b1;
                        addr_n  = REQ_A;
                        wd_n    = '0;
                        state_n = ABORT;
                    end else begin
                        gap_n   = '0;
                        state_n = GAP;
                    end
                end
            end
            ABORT: if (!avl_waitrequest) begin
                wr_n    = 1'b0;
                rv_n    = 1'b1;
                rs_n    = '0;
                rt_n    = 1'b1;
                state_n = RESP;
            end
            RESP: begin
                rdy_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) begin
            state         <= IDLE;
            opcode_q      <= '0;
            params_q      <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            poll_q        <= '0;
            gap_q         <= '0;
            avl_address   <= '0;
            avl_write     <= 1'b0;
            avl_read      <= 1'b0;
            avl_writedata <= '0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_status    <= '0;
            rsp_timeout   <= 1'b0;
        end else begin
            state         <= state_n;
            opcode_q      <= opcode_n;
            params_q      <= params_n;
            count_q       <= count_n;
            idx_q         <= idx_n;
            poll_q        <= poll_n;
            gap_q         <= gap_n;
            avl_address   <= addr_n;
            avl_write     <= wr_n;
            avl_read      <= rd_n;
            avl_writedata <= wd_n;
            cmd_ready     <= rdy_n;
            rsp_valid     <= rv_n;
            rsp_status    <= rs_n;
            rsp_timeout   <= rt_n;
        end
    end
endmodule

// File: tb/tb_seq_core_debug_cmd_initiator.sv
// Scoreboard bench for seq_core_debug_cmd_initiator: an Avalon slave model answers reads from a
// per-command status script; expected bus transfers and responses are queued when commands are issued.
module tb_seq_core_debug_cmd_initiator;
    localparam int PGAP = 3;
    localparam int MAXP = 4;

    logic         avl_clk = 1'b0;
    logic         avl_reset_n;
    logic         cmd_valid, cmd_ready;
    logic [31:0]  cmd_opcode;
    logic [2:0]   cmd_nparams;
    logic [127:0] cmd_params;
    logic         rsp_valid, rsp_timeout;
    logic [31:0]  rsp_status;
    logic [19:0]  avl_address;
    logic         avl_write, avl_read;
    logic [31:0]  avl_writedata, avl_readdata;
    logic         avl_readdatavalid, avl_waitrequest;

    seq_core_debug_cmd_initiator #(.POLL_GAP(PGAP), .MAX_POLLS(MAXP)) dut (
        .avl_clk(avl_clk), .avl_reset_n(avl_reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_nparams(cmd_nparams), .cmd_params(cmd_params),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
        .avl_address(avl_address), .avl_write(avl_write), .avl_read(avl_read),
        .avl_writedata(avl_writedata), .avl_readdata(avl_readdata),
        .avl_readdatavalid(avl_readdatavalid), .avl_waitrequest(avl_waitrequest)
    );

    always #5 avl_clk = ~avl_clk;

    typedef struct { bit wr; logic [19:0] addr; logic [31:0] data; } bus_t;
    typedef struct { logic [31:0] st; logic to; } rsp_t;
    bus_t        bus_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] stat_q[$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, hs_cyc = 0, first_rd_cyc = -1, rsp_cyc = 0, rdv_cyc = 0, last_wr_cyc = 0;
    int rsp_cnt = 0, rsp_base = 0;
    bit stall_en = 0, spurious = 0;

    always @(posedge avl_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Avalon slave model: optional 3-cycle stall per transfer, read data one cycle after acceptance.
    initial begin
        bit p_rd, p_wt;
        int stall_cnt;
        p_rd = 0; p_wt = 0; stall_cnt = 0;
        avl_waitrequest = 0; avl_readdatavalid = 0; avl_readdata = 0;
        forever begin
            @(posedge avl_clk); #1;
            if (!avl_reset_n) begin
                avl_waitrequest = 0; avl_readdatavalid = 0;
                p_rd = 0; p_wt = 0; stall_cnt = 0;
            end else begin
                avl_readdatavalid = 0;
                if (spurious) begin
                    avl_readdatavalid = 1; avl_readdata = 32'h7; spurious = 0;
                end
                if (p_rd && !p_wt) begin
                    avl_readdata = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h0;
                    avl_readdatavalid = 1;
                    if (avl_readdata != 0) rdv_cyc = cyc;
                end
                if ((avl_write || avl_read) && stall_en && stall_cnt < 3) begin
                    avl_waitrequest = 1; stall_cnt++;
                end else begin
                    avl_waitrequest = 0; stall_cnt = 0;
                end
                p_rd = avl_read; p_wt = avl_waitrequest;
            end
        end
    end

    // Monitor: transfers, stability under waitrequest, responses.
    initial begin
        bit hold_p, rd_prev, h_wr, h_rd;
        logic [19:0] h_addr;
        logic [31:0] h_data;
        bus_t e;
        rsp_t r;
        hold_p = 0; rd_prev = 0; h_wr = 0; h_rd = 0; h_addr = 0; h_data = 0;
        forever begin
            @(negedge avl_clk);
            if (!avl_reset_n) begin
                hold_p = 0; rd_prev = 0;
                chk("rsp_in_reset", 32'(rsp_valid), 32'h0);
            end else begin
                if (hold_p) begin
                    chk("hold_wr", 32'(avl_write), 32'(h_wr));
                    chk("hold_rd", 32'(avl_read), 32'(h_rd));
                    chk("hold_addr", 32'(avl_address), 32'(h_addr));
                    chk("hold_data", avl_writedata, h_data);
                end
                hold_p = (avl_write || avl_read) && avl_waitrequest;
                h_wr = avl_write; h_rd = avl_read; h_addr = avl_address; h_data = avl_writedata;
                if (avl_write || avl_read) chk("wr_rd_excl", 32'(avl_write & avl_read), 32'h0);
                if ((avl_write || avl_read) && !avl_waitrequest) begin
                    chk("bus_pending", 32'(bus_q.size() > 0), 32'h1);
                    if (bus_q.size() > 0) begin
                        e = bus_q.pop_front();
                        chk("bus_kind_wr", 32'(avl_write), 32'(e.wr));
                        chk("bus_addr", 32'(avl_address), 32'(e.addr));
                        if (avl_write) chk("bus_wdata", avl_writedata, e.data);
                    end
                    if (avl_write) last_wr_cyc = cyc;
                end
                if (avl_read && !rd_prev && first_rd_cyc < 0) first_rd_cyc = cyc;
                rd_prev = avl_read;
                if (rsp_valid) begin
                    chk("rsp_pending", 32'(rsp_q.size() > 0), 32'h1);
                    if (rsp_q.size() > 0) begin
                        r = rsp_q.pop_front();
                        chk("rsp_status", rsp_status, r.st);
                        chk("rsp_timeout", 32'(rsp_timeout), 32'(r.to));
                    end
                    rsp_cyc = cyc;
                    rsp_cnt++;
                end
            end
        end
    end

    task automatic send_cmd(input logic [31:0] op, input logic [2:0] np, input logic [127:0] pr,
                            input logic [3:0][31:0] scr, input int ns);
        int n;
        bit done, ok;
        logic [31:0] v;
        n = (np > 3'd4) ? 4 : int'(np);
        if (op == 0) begin
            rsp_q.push_back('{32'hFFFF_FFFF, 1'b0});
        end else begin
            bus_q.push_back('{1'b1, 20'h15f94, 32'h0});
            for (int k = 0; k < n; k++) bus_q.push_back('{1'b1, 20'h15f98 + 20'(4 * k), pr[32 * k +: 32]});
            bus_q.push_back('{1'b1, 20'h15f90, op});
            done = 0;
            for (int i = 0; i < MAXP && !done; i++) begin
                v = (i < ns) ? scr[i] : 32'h0;
                bus_q.push_back('{1'b0, 20'h15f94, 32'h0});
                if (v != 0) begin rsp_q.push_back('{v, 1'b0}); done = 1; end
            end
            if (!done) begin
                bus_q.push_back('{1'b1, 20'h15f90, 32'h0});
                rsp_q.push_back('{32'h0, 1'b1});
            end
            for (int i = 0; i < ns; i++) stat_q.push_back(scr[i]);
        end
        rsp_base = rsp_cnt;
        first_rd_cyc = -1;
        @(posedge avl_clk); #1;
        cmd_valid = 1; cmd_opcode = op; cmd_nparams = np; cmd_params = pr;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge avl_clk);
            if (cmd_ready) begin hs_cyc = cyc; ok = 1; end
        end
        chk("handshake", 32'(ok), 32'h1);
        @(posedge avl_clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int budget);
        for (int i = 0; i < budget && rsp_cnt <= rsp_base; i++) begin
            @(posedge avl_clk); #3;
        end
        chk("rsp_seen", 32'(rsp_cnt > rsp_base), 32'h1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        avl_reset_n = 0; cmd_valid = 0; cmd_opcode = 0; cmd_nparams = 0; cmd_params = 0;
        repeat (3) @(posedge avl_clk);
        @(negedge avl_clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_status", rsp_status, 32'h0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'h0);
        chk("rst_write", 32'(avl_write), 32'h0);
        chk("rst_read", 32'(avl_read), 32'h0);
        chk("rst_address", 32'(avl_address), 32'h0);
        chk("rst_wdata", avl_writedata, 32'h0);
        avl_reset_n = 1;
        #1 chk("rdy_before_edge", 32'(cmd_ready), 32'h0);
        @(negedge avl_clk);
        chk("rdy_after_edge", 32'(cmd_ready), 32'h1);

        // Basic success with a stray readdatavalid while idle.
        spurious = 1;
        repeat (3) @(posedge avl_clk);
        send_cmd(32'h5, 3'd2, {64'h0, 32'hB, 32'hA}, {32'h0, 32'h1, 32'h0, 32'h0}, 3);
        wait_rsp(400);
        chk("first_read_cycle", 32'(first_rd_cyc - hs_cyc), 32'(2 + 3 + PGAP));
        chk("rsp_after_rdv", 32'(rsp_cyc - rdv_cyc), 32'h1);

        // Same command with every transfer stalled.
        stall_en = 1;
        send_cmd(32'h5, 3'd2, {64'h0, 32'hB, 32'hA}, {32'h0, 32'h1, 32'h0, 32'h0}, 3);
        wait_rsp(600);
        stall_en = 0;

        // Timeout: status never leaves zero.
        send_cmd(32'h33, 3'd0, 128'h0, '0, 0);
        wait_rsp(600);
        chk("rsp_after_abort", 32'(rsp_cyc - last_wr_cyc), 32'h1);
        repeat (3) @(posedge avl_clk);
        #1 chk("timeout_held", 32'(rsp_timeout), 32'h1);

        // Illegal opcode: immediate response, no bus traffic.
        send_cmd(32'h0, 3'd3, {32'h0, 32'h3, 32'h2, 32'h1}, '0, 0);
        wait_rsp(50);
        chk("op0_rsp_cycle", 32'(rsp_cyc - hs_cyc), 32'h1);
        repeat (4) @(posedge avl_clk);
        #1 chk("op0_status_held", rsp_status, 32'hFFFF_FFFF);
        chk("op0_timeout_clr", 32'(rsp_timeout), 32'h0);

        // nparams=7 clamps to 4; a command offered while busy is ignored.
        send_cmd(32'h21, 3'd7, {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA},
                 {32'h0, 32'h0, 32'h0, 32'h1}, 1);
        @(posedge avl_clk); #1;
        cmd_valid = 1; cmd_opcode = 32'h0; cmd_nparams = 3'd0;
        @(negedge avl_clk);
        chk("busy_not_ready", 32'(cmd_ready), 32'h0);
        @(posedge avl_clk); #1;
        cmd_valid = 0;
        wait_rsp(400);

        // Reset during a parameter write, then a clean command with an error status.
        send_cmd(32'h44, 3'd3, {32'h0, 32'h3, 32'h2, 32'h1}, {96'h0, 32'h1}, 1);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge avl_clk);
            if (avl_write && avl_address == 20'h15f9c) found = 1;
        end
        chk("param_write_seen", 32'(found), 32'h1);
        #2 avl_reset_n = 0;
        #1;
        chk("mid_rst_write", 32'(avl_write), 32'h0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'h0);
        chk("mid_rst_addr", 32'(avl_address), 32'h0);
        bus_q.delete(); rsp_q.delete(); stat_q.delete();
        repeat (3) @(negedge avl_clk);
        avl_reset_n = 1;
        send_cmd(32'h45, 3'd1, {96'h0, 32'h77}, {96'h0, 32'h2}, 1);
        wait_rsp(400);

        repeat (5) @(posedge avl_clk);
        chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
